cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//   Producer side of the common data bus: collects finished results from the ALU (rs_station) and the
//   load/store unit (ls_buffer), queues them per source, and broadcasts one result per cycle on a
//   registered bus (valid/dest/value/pc). That bus feeds the issuer, rs_station, ls_buffer and ro_buffer.
//   Round-robin arbitration between sources; a mispredict flush from ro_buffer empties all queues.
// PARAMETERS
//   ROB_ID_W  4   width of a reorder-buffer id (matches `RO_BUFFER_ID_TYPE)
//   XLEN      32  width of value/pc (matches `REG_TYPE)
//   DEPTH     4   entries per source queue; power of two, >= 2
// PORTS
//   clk_in        in   1         clock
//   rst_in        in   1         synchronous reset, active-low
//   rdy_in        in   1         global ready; low = whole block frozen
//   flush_in      in   1         mispredict flush from ro_buffer
//   alu_valid_in  in   1         ALU result offered
//   alu_ready_out out  1         ALU queue can accept
//   alu_dest_in   in   ROB_ID_W  ROB id of ALU result
//   alu_value_in  in   XLEN      ALU result value
//   alu_pc_in     in   XLEN      resolved next-pc for ALU result
//   lsu_valid_in  in   1         LSU result offered
//   lsu_ready_out out  1         LSU queue can accept
//   lsu_dest_in   in   ROB_ID_W  ROB id of load/store
//   lsu_value_in  in   XLEN      load data (0 for stores)
//   bus_valid_out out  1         broadcast valid, one-cycle pulse per result
//   bus_dest_out  out  ROB_ID_W  broadcast ROB id
//   bus_value_out out  XLEN      broadcast value
//   bus_pc_out    out  XLEN      broadcast pc (0 for LSU results)
// BEHAVIOUR
//   - Reset (rst_in=0 at posedge): queues empty, bus_valid/dest/value/pc = 0, last_grant = LSU (ALU wins first tie).
//   - alu/lsu_ready_out = rst_in & rdy_in & ~flush_in & ~queue_full (combinational). No same-cycle pop credit:
//     a full queue is not ready even if it pops that cycle.
//   - Push: valid & ready at posedge writes {dest,value,pc} at wr_ptr; pointers wrap mod DEPTH; count 0..DEPTH.
//   - Arbitration each rdy_in cycle: candidates = non-empty queues; one candidate -> it; both -> the one
//     not equal to last_grant. Winner popped, last_grant updated, entry registered to bus with valid=1.
//     No candidate -> bus_valid_out=0 next cycle; dest/value/pc hold their previous value.
//   - Consumers never back-pressure; each entry appears on the bus exactly once.
//   - Latency push->bus_valid: 2 cycles (queue then output register) when uncontended.
//   - Simultaneous push and pop on the same queue: both happen, count unchanged.
//   - rdy_in=0: no push, no pop, bus registers and last_grant hold (bus_valid_out keeps its value).
//   - flush_in=1 (priority over push/pop, requires rdy_in): both queues emptied, bus_valid_out=0 next cycle,
//     inputs that cycle dropped. Reset has priority over flush.
// CONFIGURATION
//   CDB_BYPASS_EN defined: an input handshaking into an empty queue counts as a candidate that same cycle;
//     if it wins, it goes straight to the output register (never written to the queue) -> latency 1.
//     Loser of a bypass tie is queued normally. Flush still drops it.
//   CDB_BYPASS_EN undefined: all results pass through the queue; minimum latency 2.
// STRUCTURE
//   - Shared package/config.v: `RO_BUFFER_ID_TYPE, `REG_TYPE, CDB_SRC_ALU=1'b0 / CDB_SRC_LSU=1'b1 encodings.
//   - Sub-module cdb_result_fifo (params WIDTH, DEPTH; push/pop/clear, full/empty, head data),
//     instantiated twice; LSU instance stores pc as 0. Arbiter, last_grant and output register in top.
// TESTING
//   1 Reset: hold rst_in=0 2 cycles -> bus_valid_out=0, all bus fields 0, both readies 0; release -> readies 1.
//   2 Single ALU push dest=3 value=0x55 pc=0x1004 -> bus_valid 2 cycles later (1 with CDB_BYPASS_EN), fields match, one pulse.
//   3 Both sources push every cycle for 8 cycles -> bus alternates ALU,LSU,ALU,...; first is ALU; no result lost or duplicated.
//   4 DEPTH=4, bus never drains LSU side (ALU flooding irrelevant): push 4 LSU with rdy_in=0 after -> lsu_ready_out=0 while full.
//   5 Queues hold 3+2 entries, assert flush_in one cycle -> next cycle bus_valid=0, readies 1, no old entry ever appears.
//   6 rdy_in=0 for 3 cycles with pending entries -> bus outputs and counts frozen; resumes in same RR order.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Shared types, defaults and helpers for the common-data-bus arbiter.
//   - cdb_src_e : result source encoding (ALU = 1'b0, LSU = 1'b1)
//   - rr_pick   : two-way round-robin pick given candidates and last grant
package cdb_arbiter_pkg;

    localparam int ROB_ID_W_DEF = 4;   // reorder-buffer id width
    localparam int XLEN_DEF     = 32;  // register / pc width
    localparam int DEPTH_DEF    = 4;   // entries per source queue

    typedef enum logic {
        CDB_SRC_ALU = 1'b0,
        CDB_SRC_LSU = 1'b1
    } cdb_src_e;

    // With both sources requesting, the one that did not win last time goes.
    function automatic cdb_src_e rr_pick(input logic alu_cand, input logic lsu_cand,
                                         input cdb_src_e last);
        if (alu_cand && lsu_cand) begin
            return (last == CDB_SRC_ALU) ? CDB_SRC_LSU : CDB_SRC_ALU;
        end else if (lsu_cand) begin
            return CDB_SRC_LSU;
        end
        return CDB_SRC_ALU;
    endfunction

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// cdb_result_fifo
//   Per-source result queue: DEPTH entries of WIDTH bits, first-word-fall-through head.
//   Ports:
//     clk_i, rst_ni   clock, synchronous active-low reset
//     push_i, data_i  write data_i at the tail (caller guarantees not full)
//     pop_i           drop the head entry (caller guarantees not empty)
//     clear_i         empty the queue; wins over push/pop
//     full_o, empty_o occupancy flags
//     head_o          oldest entry
module cdb_result_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + 1'b1;
            if (pop_i)  rd_d = rd_q + 1'b1;
            cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by cnt_q alone.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wr_q] <= data_i;
    end

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Producer side of the common data bus. Queues finished ALU and LSU results per
//   source and broadcasts one per cycle on a registered bus, round-robin between
//   sources. A mispredict flush empties both queues.
//   Optional feature macro: CDB_BYPASS_EN -- a result handshaking into an empty
//   queue may win arbitration the same cycle and go straight to the bus register.
//   Ports:
//     clk_in, rst_in            clock, synchronous active-low reset
//     rdy_in                    global ready; low freezes the whole block
//     flush_in                  mispredict flush
//     alu_valid_in/ready_out    ALU handshake; alu_dest/value/pc_in payload
//     lsu_valid_in/ready_out    LSU handshake; lsu_dest/value_in payload (pc broadcast as 0)
//     bus_valid/dest/value/pc_out  registered broadcast
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_ID_W = ROB_ID_W_DEF,
    parameter int XLEN     = XLEN_DEF,
    parameter int DEPTH    = DEPTH_DEF
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                flush_in,
    input  logic                alu_valid_in,
    output logic                alu_ready_out,
    input  logic [ROB_ID_W-1:0] alu_dest_in,
    input  logic [XLEN-1:0]     alu_value_in,
    input  logic [XLEN-1:0]     alu_pc_in,
    input  logic                lsu_valid_in,
    output logic                lsu_ready_out,
    input  logic [ROB_ID_W-1:0] lsu_dest_in,
    input  logic [XLEN-1:0]     lsu_value_in,
    output logic                bus_valid_out,
    output logic [ROB_ID_W-1:0] bus_dest_out,
    output logic [XLEN-1:0]     bus_value_out,
    output logic [XLEN-1:0]     bus_pc_out
);

    localparam int EW = ROB_ID_W + 2 * XLEN;  // {dest, value, pc}

    logic          run, clear;
    logic          alu_full, alu_empty, lsu_full, lsu_empty;
    logic [EW-1:0] alu_head, lsu_head, alu_ent, lsu_ent, win_ent;
    logic          alu_hs, lsu_hs, alu_byp, lsu_byp;
    logic          alu_cand, lsu_cand, grant_any, alu_win, lsu_win;
    logic          alu_push, lsu_push, alu_pop, lsu_pop;
    cdb_src_e      win;

    logic          bus_vld_q, bus_vld_d;
    logic [EW-1:0] bus_ent_q, bus_ent_d;
    cdb_src_e      last_q, last_d;

    // A cycle in which queues may move; flush and freeze both stop push/pop.
    assign run   = rst_in & rdy_in & ~flush_in;
    assign clear = rst_in & rdy_in & flush_in;

    // Full queues refuse even if they pop this cycle.
    assign alu_ready_out = run & ~alu_full;
    assign lsu_ready_out = run & ~lsu_full;
    assign alu_hs        = alu_valid_in & alu_ready_out;
    assign lsu_hs        = lsu_valid_in & lsu_ready_out;

    assign alu_ent = {alu_dest_in, alu_value_in, alu_pc_in};
    assign lsu_ent = {lsu_dest_in, lsu_value_in, {XLEN{1'b0}}};

`ifdef CDB_BYPASS_EN
    assign alu_byp = alu_hs & alu_empty;
    assign lsu_byp = lsu_hs & lsu_empty;
`else
    assign alu_byp = 1'b0;
    assign lsu_byp = 1'b0;
`endif

    assign alu_cand  = run & (~alu_empty | alu_byp);
    assign lsu_cand  = run & (~lsu_empty | lsu_byp);
    assign grant_any = alu_cand | lsu_cand;
    assign win       = rr_pick(alu_cand, lsu_cand, last_q);
    assign alu_win   = grant_any & (win == CDB_SRC_ALU);
    assign lsu_win   = grant_any & (win == CDB_SRC_LSU);

    // A winner from an empty queue is a bypass: it is never written.
    assign alu_pop  = alu_win & ~alu_empty;
    assign lsu_pop  = lsu_win & ~lsu_empty;
    assign alu_push = alu_hs & ~(alu_win & alu_empty);
    assign lsu_push = lsu_hs & ~(lsu_win & lsu_empty);

    assign win_ent = (win == CDB_SRC_ALU) ? (alu_empty ? alu_ent : alu_head)
                                          : (lsu_empty ? lsu_ent : lsu_head);

    cdb_result_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_alu_q (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .push_i  (alu_push),
        .pop_i   (alu_pop),
        .clear_i (clear),
        .data_i  (alu_ent),
        .full_o  (alu_full),
        .empty_o (alu_empty),
        .head_o  (alu_head)
    );

    cdb_result_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_lsu_q (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .push_i  (lsu_push),
        .pop_i   (lsu_pop),
        .clear_i (clear),
        .data_i  (lsu_ent),
        .full_o  (lsu_full),
        .empty_o (lsu_empty),
        .head_o  (lsu_head)
    );

    // Payload holds when idle; during flush grant_any is 0 so valid drops.
    always_comb begin
        bus_vld_d = bus_vld_q;
        bus_ent_d = bus_ent_q;
        last_d    = last_q;
        if (rdy_in) begin
            bus_vld_d = grant_any;
            if (grant_any) begin
                bus_ent_d = win_ent;
                last_d    = win;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bus_vld_q <= 1'b0;
            bus_ent_q <= '0;
            last_q    <= CDB_SRC_LSU;  // ALU wins the first tie
        end else begin
            bus_vld_q <= bus_vld_d;
            bus_ent_q <= bus_ent_d;
            last_q    <= last_d;
        end
    end

    assign bus_valid_out = bus_vld_q;
    assign {bus_dest_out, bus_value_out, bus_pc_out} = bus_ent_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

`ifdef CDB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic        alu_valid_in, alu_ready_out, lsu_valid_in, lsu_ready_out;
    logic [3:0]  alu_dest_in, lsu_dest_in, bus_dest_out;
    logic [31:0] alu_value_in, alu_pc_in, lsu_value_in;
    logic        bus_valid_out;
    logic [31:0] bus_value_out, bus_pc_out;
    logic [68:0] bus_word;

    int n_assert = 0, n_fail = 0;
    int alu_n = 0, lsu_n = 0, pulses = 0;
    bit mon = 0, flood = 0;

    assign bus_word = {bus_valid_out, bus_dest_out, bus_value_out, bus_pc_out};

    cdb_arbiter #(.ROB_ID_W(4), .XLEN(32), .DEPTH(4)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_in      (flush_in),
        .alu_valid_in  (alu_valid_in),
        .alu_ready_out (alu_ready_out),
        .alu_dest_in   (alu_dest_in),
        .alu_value_in  (alu_value_in),
        .alu_pc_in     (alu_pc_in),
        .lsu_valid_in  (lsu_valid_in),
        .lsu_ready_out (lsu_ready_out),
        .lsu_dest_in   (lsu_dest_in),
        .lsu_value_in  (lsu_value_in),
        .bus_valid_out (bus_valid_out),
        .bus_dest_out  (bus_dest_out),
        .bus_value_out (bus_value_out),
        .bus_pc_out    (bus_pc_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [68:0] exp_alu(input int i);
        return {1'b1, 4'(i), 32'(32'hA00 + i), 32'(32'h2000 + i)};
    endfunction

    function automatic logic [68:0] exp_lsu(input int i);
        return {1'b1, 4'(8 + i), 32'(32'hB00 + i), 32'h0};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_alu(input int i);
        alu_valid_in = 1'b1;
        alu_dest_in  = 4'(i);
        alu_value_in = 32'(32'hA00 + i);
        alu_pc_in    = 32'(32'h2000 + i);
    endtask

    task automatic drive_lsu(input int i);
        lsu_valid_in = 1'b1;
        lsu_dest_in  = 4'(8 + i);
        lsu_value_in = 32'(32'hB00 + i);
    endtask

    // Handshakes are sampled just before the edge; outputs are checked 1 after it.
    task automatic tick();
        bit acc_a, acc_l;
        #1;
        acc_a = alu_valid_in & alu_ready_out;
        acc_l = lsu_valid_in & lsu_ready_out;
        @(posedge clk_in);
        #1;
        if (acc_a) alu_n++;
        if (acc_l) lsu_n++;
        if (mon && bus_valid_out) begin
            if (pulses % 2 == 0) chk("rr_alu_pulse", bus_word, exp_alu(pulses / 2));
            else                 chk("rr_lsu_pulse", bus_word, exp_lsu(pulses / 2));
            pulses++;
        end
        if (flood) begin
            drive_alu(alu_n);
            drive_lsu(lsu_n);
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
    endtask

    initial begin
        logic [68:0] hold;
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        alu_valid_in = 1'b0; alu_dest_in = '0; alu_value_in = '0; alu_pc_in = '0;
        lsu_valid_in = 1'b0; lsu_dest_in = '0; lsu_value_in = '0;

        // Reset held two cycles
        tick();
        tick();
        chk("rst_bus", bus_word, 0);
        chk("rst_alu_rdy", alu_ready_out, 0);
        chk("rst_lsu_rdy", lsu_ready_out, 0);
        rst_in = 1'b1;
        #1;
        chk("post_rst_alu_rdy", alu_ready_out, 1);
        chk("post_rst_lsu_rdy", lsu_ready_out, 1);

        // Single ALU result
        alu_valid_in = 1'b1; alu_dest_in = 4'd3; alu_value_in = 32'h55; alu_pc_in = 32'h1004;
        tick();
        alu_valid_in = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) tick();
            if (c == LAT) chk("single_fields", bus_word, {1'b1, 4'd3, 32'h55, 32'h1004});
            else          chk("single_no_pulse", bus_valid_out, 0);
        end

        // Both sources flood for 8 cycles
        do_reset();
        alu_n = 0; lsu_n = 0; pulses = 0;
        mon = 1; flood = 1;
        drive_alu(0);
        drive_lsu(0);
        for (int c = 1; c <= 8; c++) begin
`ifndef CDB_BYPASS_EN
            #1;
            // ALU queue hits 4 before edge 8, LSU before edge 7 (even while popping)
            chk("flood_alu_rdy", alu_ready_out, (c == 8) ? 1'b0 : 1'b1);
            chk("flood_lsu_rdy", lsu_ready_out, (c == 7) ? 1'b0 : 1'b1);
`endif
            tick();
        end
        flood = 0;
        alu_valid_in = 1'b0;
        lsu_valid_in = 1'b0;
        for (int c = 0; c < 30 && pulses < alu_n + lsu_n; c++) tick();
        chk("flood_pulses", pulses, alu_n + lsu_n);
`ifndef CDB_BYPASS_EN
        chk("flood_alu_accepted", alu_n, 7);
        chk("flood_lsu_accepted", lsu_n, 7);
`endif
        mon = 0;
        tick();
        chk("flood_idle", bus_valid_out, 0);

        // Flush with 3 ALU + 2 LSU queued
        do_reset();
        drive_alu(0);
        drive_lsu(0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c < 5) drive_alu(c); else alu_valid_in = 1'b0;
            if (c < 4) drive_lsu(c); else lsu_valid_in = 1'b0;
        end
`ifndef CDB_BYPASS_EN
        chk("prefill_last_pulse", bus_word, exp_lsu(1));
`endif
        flush_in = 1'b1;
        drive_alu(9);
        #1;
        chk("flush_alu_rdy", alu_ready_out, 0);
        tick();
        flush_in = 1'b0;
        alu_valid_in = 1'b0;
        #1;
        chk("flush_valid", bus_valid_out, 0);
        chk("flush_alu_rdy_after", alu_ready_out, 1);
        chk("flush_lsu_rdy_after", lsu_ready_out, 1);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("flush_no_stale", bus_valid_out, 0);
        end

        // Freeze with pending entries, then resume in RR order
        do_reset();
        drive_alu(0);
        drive_lsu(0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c < 3) begin
                drive_alu(c);
                drive_lsu(c);
            end else begin
                alu_valid_in = 1'b0;
                lsu_valid_in = 1'b0;
            end
        end
`ifndef CDB_BYPASS_EN
        chk("pre_freeze_bus", bus_word, exp_lsu(0));
        rdy_in = 1'b0;
        drive_alu(7);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("freeze_bus", bus_word, exp_lsu(0));
            chk("freeze_alu_rdy", alu_ready_out, 0);
        end
        alu_valid_in = 1'b0;
        rdy_in = 1'b1;
        tick(); chk("resume_a1", bus_word, exp_alu(1));
        tick(); chk("resume_l1", bus_word, exp_lsu(1));
        tick(); chk("resume_a2", bus_word, exp_alu(2));
        tick(); chk("resume_l2", bus_word, exp_lsu(2));
        tick();
        hold = exp_lsu(2);
        hold[68] = 1'b0;
        chk("resume_idle_hold", bus_word, hold);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
